// File: rtl/asic_irq4_decode.sv
// Four-source sticky interrupt collector with a maskable summary irq and a
// round-robin valid/ready port that reports which source is pending.
module asic_irq4_decode #(
   parameter string PROP = "DEFAULT",
   parameter bit    EDGE = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] in,
   input  logic [3:0] mask,
   output logic       irq,
   output logic [3:0] pending,
   output logic       valid,
   output logic [1:0] id,
   input  logic       ready
);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   state_t     state;
   logic [3:0] in_q;
   logic [3:0] set;
   logic [3:0] clr;
   logic [3:0] req;
   logic [1:0] ptr;
   logic [1:0] sel;
   logic       take;

   // First requesting source scanning upward from p, wrapping 3 -> 0.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic [1:0] pick;
      logic       found;
      pick  = p;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = p + 2'(k);
         if (!found && r[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      set  = EDGE ? (in & ~in_q) : in;
      take = valid & ready;
      clr  = take ? (4'b0001 << id) : 4'b0000;
      req  = pending & mask;
      sel  = rr_pick(req, ptr);
   end

   // Summary interrupt stays combinational on mask so unmasking is seen at once.
   assign irq = |req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_q    <= 4'b0000;
         pending <= 4'b0000;
         valid   <= 1'b0;
         id      <= 2'd0;
         ptr     <= 2'd0;
         state   <= IDLE;
      end else begin
         in_q    <= in;
         // Set is OR-ed last so a new event wins over a same-cycle clear.
         pending <= (pending & ~clr) | set;
         case (state)
            IDLE: begin
               if (|req) begin
                  id    <= sel;
                  valid <= 1'b1;
                  state <= OFFER;
               end
            end
            OFFER: begin
               if (ready) begin
                  ptr   <= id + 2'd1;
                  valid <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_asic_irq4_decode.sv
// Bench for asic_irq4_decode: edge-mode and level-mode instances share stimulus
// and are compared against a per-cycle behavioural model plus directed scenarios.
module tb_asic_irq4_decode;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] in;
   logic [3:0] mask;
   logic       ready;

   logic       a_irq, b_irq;
   logic [3:0] a_pending, b_pending;
   logic       a_valid, b_valid;
   logic [1:0] a_id, b_id;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   asic_irq4_decode #(.PROP("DEFAULT"), .EDGE(1'b1)) dut_a (
      .clk(clk), .reset(reset), .in(in), .mask(mask), .irq(a_irq),
      .pending(a_pending), .valid(a_valid), .id(a_id), .ready(ready)
   );

   asic_irq4_decode #(.PROP("DEFAULT"), .EDGE(1'b0)) dut_b (
      .clk(clk), .reset(reset), .in(in), .mask(mask), .irq(b_irq),
      .pending(b_pending), .valid(b_valid), .id(b_id), .ready(ready)
   );

   typedef struct {
      logic [3:0] pend;
      logic [3:0] inq;
      int         ptr;
      bit         vld;
      int         id;
   } mstate_t;

   mstate_t ma, mb;

   function automatic mstate_t mzero();
      mstate_t z;
      z.pend = 4'b0; z.inq = 4'b0; z.ptr = 0; z.vld = 1'b0; z.id = 0;
      return z;
   endfunction

   // One clock of the behavioural model, inputs as sampled at the edge.
   function automatic mstate_t mstep(mstate_t s, bit edge_m, logic [3:0] i,
                                     logic [3:0] m, logic r);
      mstate_t    n;
      logic [3:0] st;
      bit         found;
      int         idx;
      n  = s;
      st = edge_m ? (i & ~s.inq) : i;
      n.inq = i;
      if (s.vld) begin
         if (r) begin
            n.pend[s.id] = 1'b0;
            n.ptr = (s.id + 1) % 4;
            n.vld = 1'b0;
         end
      end else begin
         found = 1'b0;
         for (int k = 0; k < 4; k++) begin
            idx = (s.ptr + k) % 4;
            if (!found && s.pend[idx] && m[idx]) begin
               found = 1'b1;
               n.id  = idx;
               n.vld = 1'b1;
            end
         end
      end
      n.pend = n.pend | st;
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         ma = mzero();
         mb = mzero();
      end else begin
         ma = mstep(ma, 1'b1, in, mask, ready);
         mb = mstep(mb, 1'b0, in, mask, ready);
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in    = 4'b0;
      ready = 1'b0;
      ma    = mzero();
      mb    = mzero();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      mask  = 4'hF;
      ready = 1'b0;
      in    = 4'b1010;
      tick();
      in = 4'b0;
      total++;
      if (a_pending !== 4'b1010) begin
         bad++; $display("FAIL reset_pre_pending got=%b want=1010", a_pending);
      end
      tick();
      total++;
      if (a_valid !== 1'b1 || a_id !== 2'd1) begin
         bad++; $display("FAIL reset_pre_valid got v=%b id=%0d want v=1 id=1", a_valid, a_id);
      end
      #2;
      reset = 1'b1;
      ma = mzero();
      mb = mzero();
      #1;
      total++;
      if (a_pending !== 4'b0 || a_valid !== 1'b0 || a_id !== 2'd0 || a_irq !== 1'b0) begin
         bad++; $display("FAIL reset_async got p=%b v=%b id=%0d irq=%b want all 0",
                         a_pending, a_valid, a_id, a_irq);
      end
      total++;
      if (b_pending !== 4'b0 || b_valid !== 1'b0 || b_irq !== 1'b0) begin
         bad++; $display("FAIL reset_async_b got p=%b v=%b irq=%b want all 0",
                         b_pending, b_valid, b_irq);
      end
      tick();
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         total++;
         if (a_pending !== 4'b0 || a_valid !== 1'b0 || a_id !== 2'd0 || a_irq !== 1'b0) begin
            bad++; $display("FAIL reset_idle cyc=%0d got p=%b v=%b id=%0d irq=%b want 0",
                            c, a_pending, a_valid, a_id, a_irq);
         end
      end
   endtask

   task automatic test_single_event();
      mask  = 4'hF;
      ready = 1'b1;
      in    = 4'b0100;
      tick();
      in = 4'b0;
      total++;
      if (a_pending !== 4'b0100 || a_irq !== 1'b1 || a_valid !== 1'b0) begin
         bad++; $display("FAIL single_set got p=%b irq=%b v=%b want p=0100 irq=1 v=0",
                         a_pending, a_irq, a_valid);
      end
      tick();
      total++;
      if (a_valid !== 1'b1 || a_id !== 2'd2) begin
         bad++; $display("FAIL single_offer got v=%b id=%0d want v=1 id=2", a_valid, a_id);
      end
      tick();
      total++;
      if (a_pending !== 4'b0 || a_irq !== 1'b0 || a_valid !== 1'b0) begin
         bad++; $display("FAIL single_clear got p=%b irq=%b v=%b want 0", a_pending, a_irq, a_valid);
      end
   endtask

   task automatic test_round_robin();
      int got_id[$];
      int got_cyc[$];
      do_reset();
      mask  = 4'hF;
      ready = 1'b1;
      for (int burst = 0; burst < 2; burst++) begin
         got_id.delete();
         got_cyc.delete();
         in = 4'hF;
         tick();
         in = 4'b0;
         for (int c = 0; c < 10; c++) begin
            tick();
            if (a_valid) begin
               got_id.push_back(int'(a_id));
               got_cyc.push_back(c);
            end
         end
         total++;
         if (got_id.size() != 4) begin
            bad++; $display("FAIL rr_count burst=%0d got=%0d want=4", burst, got_id.size());
         end else begin
            for (int k = 0; k < 4; k++) begin
               total++;
               if (got_id[k] != k || got_cyc[k] != got_cyc[0] + 2 * k) begin
                  bad++; $display("FAIL rr_order burst=%0d k=%0d got id=%0d cyc=%0d want id=%0d cyc=%0d",
                                  burst, k, got_id[k], got_cyc[k], k, got_cyc[0] + 2 * k);
               end
            end
            total++;
            if (got_cyc[0] != 0) begin
               bad++; $display("FAIL rr_latency burst=%0d got=%0d want=0", burst, got_cyc[0]);
            end
         end
      end
   endtask

   task automatic test_masking();
      bit seen;
      ready = 1'b0;
      mask  = 4'b0001;
      in    = 4'b1000;
      tick();
      in = 4'b0;
      total++;
      if (a_pending !== 4'b1000 || a_irq !== 1'b0) begin
         bad++; $display("FAIL mask_pending got p=%b irq=%b want p=1000 irq=0", a_pending, a_irq);
      end
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (a_valid) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++; $display("FAIL mask_no_valid got valid=1 want valid=0");
      end
      #2;
      mask = 4'hF;
      #1;
      total++;
      if (a_irq !== 1'b1) begin
         bad++; $display("FAIL mask_irq_comb got=%b want=1", a_irq);
      end
      tick();
      total++;
      if (a_valid !== 1'b1 || a_id !== 2'd3) begin
         bad++; $display("FAIL mask_offer got v=%b id=%0d want v=1 id=3", a_valid, a_id);
      end
      ready = 1'b1;
      tick();
      total++;
      if (a_valid !== 1'b0 || a_pending !== 4'b0) begin
         bad++; $display("FAIL mask_clear got v=%b p=%b want v=0 p=0000", a_valid, a_pending);
      end
   endtask

   task automatic test_collision();
      do_reset();
      mask  = 4'hF;
      in    = 4'b0010;
      tick();
      total++;
      if (b_pending !== 4'b0010) begin
         bad++; $display("FAIL coll_set got=%b want=0010", b_pending);
      end
      tick();
      total++;
      if (b_valid !== 1'b1 || b_id !== 2'd1) begin
         bad++; $display("FAIL coll_offer got v=%b id=%0d want v=1 id=1", b_valid, b_id);
      end
      ready = 1'b1;
      tick();
      total++;
      if (b_pending[1] !== 1'b1 || b_valid !== 1'b0) begin
         bad++; $display("FAIL coll_hold got p=%b v=%b want p[1]=1 v=0", b_pending, b_valid);
      end
      total++;
      if (a_pending !== 4'b0) begin
         bad++; $display("FAIL coll_edge_clear got=%b want=0000", a_pending);
      end
      tick();
      total++;
      if (b_valid !== 1'b1 || b_id !== 2'd1 || a_valid !== 1'b0) begin
         bad++; $display("FAIL coll_reoffer got bv=%b bid=%0d av=%b want bv=1 bid=1 av=0",
                         b_valid, b_id, a_valid);
      end
      in = 4'b0;
      tick();
      total++;
      if (b_pending !== 4'b0 || b_valid !== 1'b0) begin
         bad++; $display("FAIL coll_drain got p=%b v=%b want p=0000 v=0", b_pending, b_valid);
      end
   endtask

   task automatic test_stall();
      do_reset();
      mask = 4'hF;
      in   = 4'b0001;
      tick();
      in = 4'b0;
      tick();
      total++;
      if (a_valid !== 1'b1 || a_id !== 2'd0) begin
         bad++; $display("FAIL stall_offer got v=%b id=%0d want v=1 id=0", a_valid, a_id);
      end
      for (int c = 0; c < 20; c++) begin
         in = (c == 3) ? 4'b0010 : 4'b0000;
         tick();
         total++;
         if (a_valid !== 1'b1 || a_id !== 2'd0) begin
            bad++; $display("FAIL stall_hold cyc=%0d got v=%b id=%0d want v=1 id=0", c, a_valid, a_id);
         end
      end
      total++;
      if (a_pending !== 4'b0011) begin
         bad++; $display("FAIL stall_pending got=%b want=0011", a_pending);
      end
      ready = 1'b1;
      tick();
      total++;
      if (a_valid !== 1'b0 || a_pending !== 4'b0010) begin
         bad++; $display("FAIL stall_accept got v=%b p=%b want v=0 p=0010", a_valid, a_pending);
      end
      tick();
      total++;
      if (a_valid !== 1'b1 || a_id !== 2'd1) begin
         bad++; $display("FAIL stall_next got v=%b id=%0d want v=1 id=1", a_valid, a_id);
      end
      tick();
   endtask

   task automatic test_random();
      logic ma_irq, mb_irq;
      do_reset();
      mask = 4'($urandom);
      for (int c = 0; c < 600; c++) begin
         in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         ready = 1'($urandom);
         if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
         tick();
         ma_irq = |(ma.pend & mask);
         mb_irq = |(mb.pend & mask);
         total++;
         if (a_pending !== ma.pend || a_valid !== ma.vld || a_id !== 2'(ma.id) || a_irq !== ma_irq) begin
            bad++; $display("FAIL rand_edge cyc=%0d got p=%b v=%b id=%0d irq=%b want p=%b v=%b id=%0d irq=%b",
                            c, a_pending, a_valid, a_id, a_irq, ma.pend, ma.vld, ma.id, ma_irq);
         end
         total++;
         if (b_pending !== mb.pend || b_valid !== mb.vld || b_id !== 2'(mb.id) || b_irq !== mb_irq) begin
            bad++; $display("FAIL rand_level cyc=%0d got p=%b v=%b id=%0d irq=%b want p=%b v=%b id=%0d irq=%b",
                            c, b_pending, b_valid, b_id, b_irq, mb.pend, mb.vld, mb.id, mb_irq);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      in    = 4'b0;
      mask  = 4'b0;
      ready = 1'b0;
      ma    = mzero();
      mb    = mzero();
      tick();
      tick();
      reset = 1'b0;
      test_reset();
      test_single_event();
      test_round_robin();
      test_masking();
      test_collision();
      test_stall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
